// File: rtl/pipelined_adder_acc.sv
// rtl/pipelined_adder_acc.sv - chunked pipelined adder/subtractor with accumulator and valid/ready handshakes
module pipelined_adder_acc #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [WIDTH-1:0] acc
);

    localparam int STAGES = (WIDTH / CHUNK < 1) ? 1 : WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    // st_* hold the inputs of stage k: full operands, partial sum and carry into chunk k
    logic [STAGES-1:0] st_vld;
    logic [WIDTH-1:0]  st_x  [STAGES];
    logic [WIDTH-1:0]  st_y  [STAGES];
    logic [WIDTH-1:0]  st_s  [STAGES];
    logic              st_c  [STAGES];
    logic [1:0]        st_op [STAGES];

    logic [CHUNK:0]    t     [STAGES];
    logic [WIDTH-1:0]  nx_s  [STAGES];
    logic              nx_c  [STAGES];

    logic [1:0]        out_op;
    logic              init_done;
    logic              adv;
    logic              acc_busy;
    logic [WIDTH-1:0]  fx;
    logic [WIDTH-1:0]  fy;
    logic              fc;

    assign adv      = !(out_valid && !out_ready);
    assign in_ready = init_done && adv && !acc_busy;

    always_comb begin
        fx = '0;
        fy = '0;
        fc = 1'b0;
        case (mode)
            2'b00: begin fx = a;   fy = b;  fc = 1'b0; end
            2'b01: begin fx = a;   fy = ~b; fc = 1'b1; end
            2'b10: begin fx = acc; fy = a;  fc = 1'b0; end
            default: begin fx = '0; fy = '0; fc = 1'b0; end
        endcase
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            t[k] = {1'b0, st_x[k][k*CHUNK +: CHUNK]} + {1'b0, st_y[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, st_c[k]};
            nx_s[k] = st_s[k];
            nx_s[k][k*CHUNK +: CHUNK] = t[k][CHUNK-1:0];
            nx_c[k] = t[k][CHUNK];
        end
    end

    // Any acc-affecting op anywhere in flight blocks new input until its result is consumed
    always_comb begin
        acc_busy = out_valid && out_op[1];
        for (int k = 0; k < STAGES; k++) begin
            if (st_vld[k] && st_op[k][1]) begin
                acc_busy = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done <= 1'b0;
            st_vld    <= '0;
            for (int k = 0; k < STAGES; k++) begin
                st_x[k]  <= '0;
                st_y[k]  <= '0;
                st_s[k]  <= '0;
                st_c[k]  <= 1'b0;
                st_op[k] <= 2'b00;
            end
            out_valid <= 1'b0;
            out_op    <= 2'b00;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            acc       <= '0;
        end else begin
            init_done <= 1'b1;
            if (adv) begin
                st_vld[0] <= in_valid && in_ready;
                st_x[0]   <= fx;
                st_y[0]   <= fy;
                st_s[0]   <= '0;
                st_c[0]   <= fc;
                st_op[0]  <= mode;
                for (int k = 1; k < STAGES; k++) begin
                    st_vld[k] <= st_vld[k-1];
                    st_x[k]   <= st_x[k-1];
                    st_y[k]   <= st_y[k-1];
                    st_s[k]   <= nx_s[k-1];
                    st_c[k]   <= nx_c[k-1];
                    st_op[k]  <= st_op[k-1];
                end
                out_valid <= st_vld[LAST];
                if (st_vld[LAST]) begin
                    sum    <= nx_s[LAST];
                    cout   <= nx_c[LAST];
                    ovf    <= (st_x[LAST][WIDTH-1] == st_y[LAST][WIDTH-1])
                           && (nx_s[LAST][WIDTH-1] != st_x[LAST][WIDTH-1]);
                    out_op <= st_op[LAST];
                end
            end
            if (out_valid && out_ready) begin
                if (out_op == 2'b10) begin
                    acc <= sum;
                end else if (out_op == 2'b11) begin
                    acc <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_adder_acc.sv
// tb/tb_pipelined_adder_acc.sv - scoreboard bench for pipelined_adder_acc with random and directed stimulus
module tb_pipelined_adder_acc;

    localparam int W      = 16;
    localparam int STAGES = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [1:0]    mode = 2'b00;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic [W-1:0]  acc;

    pipelined_adder_acc #(.WIDTH(W), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .acc(acc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         c;
        logic         v;
        logic [1:0]   mode;
        logic [W-1:0] acc;
        int           cyc;
        bit           lat;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] model_acc = '0;
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Reference: results from plain integer arithmetic on the raw operands
    task automatic send(input logic [1:0] m, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input bit rnd, input int exp_wait);
        int           w;
        int           s;
        logic [W:0]   r;
        exp_t         e;
        w = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; mode = m; a = aa; b = bb;
        if (rnd) out_ready = ($urandom_range(0, 3) != 0);
        #1;
        while (!in_ready && w < 200) begin
            @(posedge clk); #1;
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            w++;
        end
        if (!in_ready) begin
            chk(1'b0, "in_ready_timeout", 32'(w), 32'd200);
            in_valid = 1'b0;
            return;
        end
        if (exp_wait >= 0) chk(w == exp_wait, "acc_hazard_wait", 32'(w), 32'(exp_wait));
        case (m)
            2'b00: begin
                r   = {1'b0, aa} + {1'b0, bb};
                e.c = r[W];
                s   = int'($signed(aa)) + int'($signed(bb));
            end
            2'b01: begin
                r   = {1'b0, aa} - {1'b0, bb};
                e.c = (aa >= bb);
                s   = int'($signed(aa)) - int'($signed(bb));
            end
            2'b10: begin
                r   = {1'b0, model_acc} + {1'b0, aa};
                e.c = r[W];
                s   = int'($signed(model_acc)) + int'($signed(aa));
                model_acc = r[W-1:0];
            end
            default: begin
                r   = '0;
                e.c = 1'b0;
                s   = 0;
                model_acc = '0;
            end
        endcase
        e.sum  = r[W-1:0];
        e.v    = (s > 32767) || (s < -32768);
        e.mode = m;
        e.acc  = model_acc;
        e.cyc  = cyc + 1;
        e.lat  = !rnd && out_ready;
        q.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(n < 200, "drain_timeout", 32'(q.size()), 32'd0);
    endtask

    // Monitor: compares each presented result against the scoreboard head
    bit           held = 1'b0;
    logic [W+1:0] held_val;
    bit           acc_chk = 1'b0;
    logic [W-1:0] acc_exp;
    exp_t         hd;

    always @(negedge clk) begin
        if (!rst_n) begin
            held    = 1'b0;
            acc_chk = 1'b0;
        end else begin
            if (acc_chk) begin
                chk(acc == acc_exp, "acc_update", 32'(acc), 32'(acc_exp));
                acc_chk = 1'b0;
            end
            if (held)
                chk({out_valid, sum, cout, ovf} == {1'b1, held_val}, "hold_stable",
                    32'({out_valid, sum, cout, ovf}), 32'({1'b1, held_val}));
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk(1'b0, "stale_output", 32'(sum), 32'd0);
                end else begin
                    hd = q[0];
                    if (!held) begin
                        chk({sum, cout, ovf} == {hd.sum, hd.c, hd.v}, "result",
                            32'({sum, cout, ovf}), 32'({hd.sum, hd.c, hd.v}));
                        if (hd.lat) chk(cyc == hd.cyc + STAGES, "latency", 32'(cyc), 32'(hd.cyc + STAGES));
                    end
                    if (out_ready) begin
                        void'(q.pop_front());
                        held = 1'b0;
                        if (hd.mode[1]) begin
                            acc_chk = 1'b1;
                            acc_exp = hd.acc;
                        end
                    end else begin
                        held     = 1'b1;
                        held_val = {sum, cout, ovf};
                    end
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int m;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk({out_valid, sum, cout, ovf, acc} == '0, "reset_state", 32'({out_valid, cout, ovf, sum}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk(in_ready == 1'b1, "ready_after_reset", 32'(in_ready), 32'd1);

        // Inter-stage carry with exact latency
        send(2'b00, 16'h00FF, 16'h0001, 1'b0, -1);
        idle(); drain();

        // Back-to-back stream
        send(2'b00, 16'h7FFF, 16'h0001, 1'b0, -1);
        send(2'b00, 16'hFFFF, 16'h0001, 1'b0, -1);
        send(2'b00, 16'h1234, 16'h4321, 1'b0, -1);
        idle(); drain();

        // Subtract
        send(2'b01, 16'h0005, 16'h0007, 1'b0, -1);
        send(2'b01, 16'h8000, 16'h0001, 1'b0, -1);
        idle(); drain();

        // Accumulate sequence; each follower must wait for the acc op's handshake
        send(2'b10, 16'h0003, 16'h0000, 1'b0, -1);
        send(2'b10, 16'h0004, 16'h0000, 1'b0, STAGES + 1);
        send(2'b11, 16'h0000, 16'h0000, 1'b0, STAGES + 1);
        send(2'b10, 16'h0009, 16'h0000, 1'b0, STAGES + 1);
        send(2'b00, 16'h0001, 16'h0001, 1'b0, STAGES + 1);
        idle(); drain();

        // Backpressure with full pipeline
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(2'b00, 16'h1111, 16'h0001, 1'b0, -1);
        send(2'b01, 16'h2222, 16'h0002, 1'b0, -1);
        send(2'b00, 16'h3333, 16'h0003, 1'b0, -1);
        idle();
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk({out_valid, in_ready} == 2'b10, "stall_flags", 32'({out_valid, in_ready}), 32'b10);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();
        chk(q.size() == 0, "stall_all_drained", 32'(q.size()), 32'd0);

        // Mid-stream asynchronous reset with acc = 7
        send(2'b11, 16'h0000, 16'h0000, 1'b0, -1);
        send(2'b10, 16'h0007, 16'h0000, 1'b0, STAGES + 1);
        idle(); drain();
        chk(acc == 16'h0007, "acc_before_reset", 32'(acc), 32'h7);
        send(2'b00, 16'h0100, 16'h0200, 1'b0, -1);
        send(2'b00, 16'h0300, 16'h0400, 1'b0, -1);
        @(posedge clk); #3;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk({out_valid, acc} == '0, "async_reset_clears", 32'({out_valid, acc}), 32'd0);
        q.delete();
        model_acc = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(2'b10, 16'h0042, 16'h0000, 1'b0, -1);
        idle(); drain();

        // Randomised traffic with random backpressure
        for (int i = 0; i < 80; i++) begin
            m = $urandom_range(0, 9);
            send((m < 4) ? 2'b00 : (m < 8) ? 2'b01 : (m < 9) ? 2'b10 : 2'b11,
                 16'($urandom), 16'($urandom), 1'b1, -1);
        end
        idle();
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();
        chk(acc == model_acc, "acc_final", 32'(acc), 32'(model_acc));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
